// File: rtl/camera_control_pkg.sv
// Shared definitions for the camera frame buffer scheduler: queue markers, scheduler states
// and memory-side widths.
package camera_control_pkg;

  localparam int unsigned Q_WORD_W   = 17;
  localparam int unsigned Q_COUNT_W  = 10;
  localparam int unsigned MEM_DATA_W = 16;

  localparam logic [Q_WORD_W-1:0] Q_FRAME_START = 17'h10000;
  localparam logic [Q_WORD_W-1:0] Q_ROW_START   = 17'h10001;
  localparam logic [Q_WORD_W-1:0] Q_FRAME_END   = 17'h1FFFF;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_PARSE   = 3'd1,
    ST_WR_CMD  = 3'd2,
    ST_WR_DATA = 3'd3,
    ST_WR_WAIT = 3'd4,
    ST_RD_CMD  = 3'd5,
    ST_RD_WAIT = 3'd6
  } state_t;

endpackage

// File: rtl/burst_addr_gen.sv
// Write address generator: tracks the pixel write pointer, the current row base and whether
// a row has been started in this frame.
module burst_addr_gen
  import camera_control_pkg::*;
#(
  parameter int unsigned FRAME_WIDTH = 640,
  parameter int unsigned BURST_LEN   = 32,
  parameter int unsigned PTR_WIDTH   = 20
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 frame_start,
  input  logic                 row_start,
  input  logic                 burst_done,
  output logic [PTR_WIDTH-1:0] wr_addr
);

  localparam logic [PTR_WIDTH-1:0] ROW_INC   = PTR_WIDTH'(FRAME_WIDTH);
  localparam logic [PTR_WIDTH-1:0] BURST_INC = PTR_WIDTH'(BURST_LEN);

  logic [PTR_WIDTH-1:0] wr_ptr;
  logic [PTR_WIDTH-1:0] row_base;
  logic [PTR_WIDTH-1:0] row_base_next;
  logic                 row_seen;

  // The first row of a frame starts at the current base; later rows advance by one row.
  always_comb begin
    row_base_next = row_seen ? row_base + ROW_INC : row_base;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr   <= '0;
      row_base <= '0;
      row_seen <= 1'b0;
    end else if (frame_start) begin
      wr_ptr   <= '0;
      row_base <= '0;
      row_seen <= 1'b0;
    end else if (row_start) begin
      row_base <= row_base_next;
      wr_ptr   <= row_base_next;
      row_seen <= 1'b1;
    end else if (burst_done) begin
      wr_ptr <= wr_ptr + BURST_INC;
    end
  end

  assign wr_addr = wr_ptr;

endmodule

// File: rtl/frame_buffer_scheduler.sv
// Camera queue to SDRAM scheduler with double-buffered frame store and display read arbitration.
// Optional statistics counters are enabled by defining FRAME_SCHED_STATS_EN.
module frame_buffer_scheduler
  import camera_control_pkg::*;
#(
  parameter int unsigned FRAME_WIDTH  = 640,
  parameter int unsigned FRAME_HEIGHT = 480,
  parameter int unsigned BURST_LEN    = 32,
  parameter int unsigned ADDR_WIDTH   = 21,
  parameter int unsigned WQ_HIGH      = 384
) (
  input  logic                    MemClk,
  input  logic                    RST,
  input  logic [Q_WORD_W-1:0]     wq_data,
  input  logic                    wq_empty,
  input  logic [Q_COUNT_W-1:0]    wq_count,
  output logic                    wq_rd_en,
  input  logic                    rd_req,
  input  logic [ADDR_WIDTH-2:0]   rd_addr,
  output logic                    rd_grant,
  output logic                    rd_done,
  output logic                    mem_cmd_valid,
  input  logic                    mem_cmd_ready,
  output logic                    mem_cmd_write,
  output logic [ADDR_WIDTH-1:0]   mem_cmd_addr,
  output logic [MEM_DATA_W-1:0]   mem_wr_data,
  output logic                    mem_wr_valid,
  input  logic                    mem_wr_ready,
  input  logic                    mem_burst_done,
  output logic                    frame_bank,
  output logic                    frame_done
`ifdef FRAME_SCHED_STATS_EN
  ,
  output logic [15:0]             stat_frames,
  output logic [15:0]             stat_bursts_wr
`endif
);

  localparam int unsigned BEAT_W = $clog2(BURST_LEN + 1);
  localparam logic [BEAT_W-1:0]    BEAT_LAST = BEAT_W'(BURST_LEN - 1);
  localparam logic [Q_COUNT_W-1:0] BURST_CNT = Q_COUNT_W'(BURST_LEN);
  localparam logic [Q_COUNT_W-1:0] HIGH_CNT  = Q_COUNT_W'(WQ_HIGH);

  if ((FRAME_WIDTH % BURST_LEN) != 0) begin : g_width_check
    $error("FRAME_WIDTH must be a multiple of BURST_LEN");
  end

  state_t              state, state_next;
  logic                last_rd, last_rd_next;
  logic [BEAT_W-1:0]   beat;
  logic [ADDR_WIDTH-2:0] wr_addr;
  logic                is_marker, w_ready, r_ready;
  logic                in_parse, word_accept, burst_last;
  logic                ev_frame_start, ev_row_start;

  assign is_marker   = !wq_empty && wq_data[16];
  assign w_ready     = !wq_empty && !wq_data[16] && (wq_count >= BURST_CNT);
  assign r_ready     = rd_req;
  assign in_parse    = (state == ST_PARSE);
  assign word_accept = (state == ST_WR_DATA) && mem_wr_ready;
  assign burst_last  = word_accept && (beat == BEAT_LAST);

  assign ev_frame_start = in_parse && (wq_data == Q_FRAME_START);
  assign ev_row_start   = in_parse && (wq_data == Q_ROW_START);

  always_comb begin
    state_next   = state;
    last_rd_next = last_rd;
    unique case (state)
      ST_IDLE: begin
        if (is_marker) begin
          state_next = ST_PARSE;
        // A write wins when alone, above the watermark, or when the read won the last pick.
        end else if (w_ready && (!r_ready || (wq_count >= HIGH_CNT) || last_rd)) begin
          state_next   = ST_WR_CMD;
          last_rd_next = 1'b0;
        end else if (r_ready) begin
          state_next   = ST_RD_CMD;
          last_rd_next = 1'b1;
        end
      end
      ST_PARSE:   state_next = ST_IDLE;
      ST_WR_CMD:  if (mem_cmd_ready) state_next = ST_WR_DATA;
      ST_WR_DATA: if (burst_last) state_next = ST_WR_WAIT;
      ST_WR_WAIT: if (mem_burst_done) state_next = ST_IDLE;
      ST_RD_CMD:  if (mem_cmd_ready) state_next = ST_RD_WAIT;
      ST_RD_WAIT: if (mem_burst_done) state_next = ST_IDLE;
      default:    state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge MemClk or posedge RST) begin
    if (RST) begin
      state      <= ST_IDLE;
      last_rd    <= 1'b0;
      beat       <= '0;
      frame_bank <= 1'b0;
    end else begin
      state   <= state_next;
      last_rd <= last_rd_next;
      if (word_accept) beat <= burst_last ? '0 : beat + 1'b1;
      if (frame_done) frame_bank <= ~frame_bank;
    end
  end

  burst_addr_gen #(
    .FRAME_WIDTH (FRAME_WIDTH),
    .BURST_LEN   (BURST_LEN),
    .PTR_WIDTH   (ADDR_WIDTH - 1)
  ) u_addr_gen (
    .clk         (MemClk),
    .rst         (RST),
    .frame_start (ev_frame_start),
    .row_start   (ev_row_start),
    .burst_done  (burst_last),
    .wr_addr     (wr_addr)
  );

  always_comb begin
    mem_cmd_addr = '0;
    if (state == ST_WR_CMD) mem_cmd_addr = {frame_bank, wr_addr};
    else if (state == ST_RD_CMD) mem_cmd_addr = {~frame_bank, rd_addr};
  end

  assign wq_rd_en      = in_parse || word_accept;
  assign frame_done    = in_parse && (wq_data == Q_FRAME_END);
  assign mem_cmd_valid = (state == ST_WR_CMD) || (state == ST_RD_CMD);
  assign mem_cmd_write = (state == ST_WR_CMD);
  assign mem_wr_valid  = (state == ST_WR_DATA);
  assign mem_wr_data   = mem_wr_valid ? wq_data[15:0] : '0;
  assign rd_grant      = (state == ST_RD_CMD) && mem_cmd_ready;
  assign rd_done       = (state == ST_RD_WAIT) && mem_burst_done;

`ifdef FRAME_SCHED_STATS_EN
  always_ff @(posedge MemClk or posedge RST) begin
    if (RST) begin
      stat_frames    <= '0;
      stat_bursts_wr <= '0;
    end else begin
      if (frame_done) stat_frames <= stat_frames + 16'd1;
      if ((state == ST_WR_WAIT) && mem_burst_done) stat_bursts_wr <= stat_bursts_wr + 16'd1;
    end
  end
`endif

endmodule

// File: doc/frame_buffer_scheduler.md
Name: frame_buffer_scheduler

Overview:
Sits between the camera queue FIFO (17-bit words, FWFT read side) and the SDRAM memory controller command/data port.
- Parses the queue marker stream: 0x10000 frame start, 0x10001 row start, 0x1FFFF frame end; bit16=0 is a pixel.
- Schedules BURST_LEN-word pixel write bursts into a double-buffered frame store.
- Arbitrates the single memory port against burst read requests from the display path.
- Swaps the write bank at each frame end.

Parameters:
FRAME_WIDTH, 640, pixels per row; must be a multiple of BURST_LEN (elaboration-time check).
FRAME_HEIGHT, 480, rows per frame.
BURST_LEN, 32, words per memory burst.
ADDR_WIDTH, 21, word address width; MSB selects the bank.
WQ_HIGH, 384, queue-level watermark above which writes take priority over reads.

Ports:
MemClk  in  1  single clock; all logic on its rising edge.
RST  in  1  asynchronous, active-high reset.
wq_data  in  17  queue head word (FWFT).
wq_empty  in  1  queue empty.
wq_count  in  10  queue occupancy in words.
wq_rd_en  out  1  pop queue head.
rd_req  in  1  display burst request; held until rd_grant.
rd_addr  in  ADDR_WIDTH-1  word offset within the display bank.
rd_grant  out  1  one-cycle pulse when the read command is accepted.
rd_done  out  1  one-cycle pulse at read burst completion.
mem_cmd_valid  out  1  command valid.
mem_cmd_ready  in  1  controller accepts command.
mem_cmd_write  out  1  1=write burst, 0=read burst.
mem_cmd_addr  out  ADDR_WIDTH  burst start address.
mem_wr_data  out  16  write data (wq_data[15:0]).
mem_wr_valid  out  1  write word valid.
mem_wr_ready  in  1  controller accepts write word.
mem_burst_done  in  1  one-cycle pulse when the current burst completes.
frame_bank  out  1  bank currently being written; the display reads ~frame_bank.
frame_done  out  1  one-cycle pulse on frame-end marker.

Behaviour:
- Reset (asynchronous, any state, including mid-burst): state=IDLE; all outputs 0; frame_bank=0; wr_ptr=0; row_base=0; row_seen=0. The memory controller shares RST.
- States: IDLE, PARSE, WR_CMD, WR_DATA, WR_WAIT, RD_CMD, RD_WAIT.
- IDLE: if !wq_empty and wq_data[16]=1, go to PARSE. Otherwise pick the next operation:
  - W ready when the head is a pixel and wq_count>=BURST_LEN.
  - R ready when rd_req=1.
  - Only one ready: take it. Both ready: W if wq_count>=WQ_HIGH; otherwise alternate, taking whichever did not win last (last_rd flag, reset 0, so R wins the first tie).
- PARSE, one cycle; wq_rd_en=1 pops the marker.
  - 0x10000: wr_ptr=0, row_base=0, row_seen=0; no bank swap.
  - 0x10001: if row_seen, row_base+=FRAME_WIDTH; wr_ptr=row_base (new value); row_seen=1.
  - 0x1FFFF: frame_bank toggles and frame_done pulses, whether or not all rows arrived.
  - Any other word with bit16=1: popped and ignored.
  - Always returns to IDLE.
- WR_CMD:
  - mem_cmd_valid=1, mem_cmd_write=1, mem_cmd_addr={frame_bank, wr_ptr[ADDR_WIDTH-2:0]}.
  - Hold until mem_cmd_ready, then go to WR_DATA.
- WR_DATA:
  - mem_wr_valid=1 and mem_wr_data=wq_data[15:0].
  - wq_rd_en = mem_wr_ready; the head is guaranteed to be a pixel because bursts never straddle a row.
  - Counts BURST_LEN accepted words, then goes to WR_WAIT; wr_ptr += BURST_LEN.
- WR_WAIT: on mem_burst_done, go to IDLE.
- RD_CMD:
  - mem_cmd_valid=1, mem_cmd_write=0, mem_cmd_addr={~frame_bank, rd_addr}.
  - On mem_cmd_ready, pulse rd_grant and go to RD_WAIT.
- RD_WAIT: on mem_burst_done, pulse rd_done and go to IDLE.
- Latency:
  - Marker pop: 2 cycles from the head appearing.
  - Write command: issued the cycle after the IDLE decision.
- Bank swap vs. in-flight read:
  - A read command already accepted keeps its latched bank.
  - A bank swap occurs only in PARSE, so it never coincides with an active burst.
- wr_ptr wraps modulo 2^(ADDR_WIDTH-1).
- rd_req dropped before grant: IDLE re-evaluates every cycle, but RD_CMD, once entered, completes.

Optional Feature:
FRAME_SCHED_STATS_EN
- Defined: adds outputs stat_frames (16 bit) and stat_bursts_wr (16 bit), both incrementing and wrapping, both cleared by RST.
  - stat_frames increments on frame_done.
  - stat_bursts_wr increments on write-burst completion.
- Undefined: ports and counters absent; behaviour otherwise identical.

Decomposition:
- Shared package camera_control_pkg holds:
  - the marker constants (Q_FRAME_START=17'h10000, Q_ROW_START=17'h10001, Q_FRAME_END=17'h1FFFF);
  - the scheduler state_t enum;
  - the memory command width constants.
- One sub-module, burst_addr_gen: owns wr_ptr, row_base and row_seen, with inputs for frame-start, row-start and burst-done events and an output for the current write address.

Test Plan:
- Reset, then frame start, row start, 640 pixels, frame end queued -> 20 write commands at addresses 0,32,…,608 in bank 0; frame_done pulses once; frame_bank=1.
- Second row start -> first write of that row at address 640.
- rd_req held with wq_count=100 and last_rd=0 -> read granted first, then write; addresses {~frame_bank, rd_addr}; rd_done follows mem_burst_done.
- wq_count=400 (≥WQ_HIGH) with rd_req=1 on consecutive decisions -> writes win until wq_count<384.
- mem_wr_ready toggling 50% during WR_DATA -> exactly 32 pops; wq_rd_en only when mem_wr_ready=1.
- Frame start mid-frame without frame end -> wr_ptr=0, no bank toggle.
- RST asserted mid WR_DATA -> outputs 0 asynchronously; state IDLE; frame_bank=0.
